// File: rtl/fake_rd_pkg.sv
// Shared constants and helpers for the fake RD AXI4-Lite register bank.
package fake_rd_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    function automatic int addr_lsb(input int dw);
        return clog2(dw / 8);
    endfunction

endpackage

// File: rtl/fake_rd_axi_hold.sv
// One-entry valid/ready holding register; accepts a beat, keeps it until cleared.
module fake_rd_axi_hold #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_clr,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    assign o_ready = i_en & ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // Accept only when empty and clear only when full, so the two never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/fake_rd_axi_regbank.sv
// AXI4-Lite slave register bank with byte strobes, RO status words and write pulses.
// Build option FAKE_RD_SLVERR_EN: DECERR for out-of-range and SLVERR for RO writes.
module fake_rd_axi_regbank
    import fake_rd_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 8,
    parameter int                  NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                s_axi_aclk,
    input  logic                                s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic [2:0]                          s_axi_awprot,
    input  logic                                s_axi_awvalid,
    output logic                                s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s_axi_wstrb,
    input  logic                                s_axi_wvalid,
    output logic                                s_axi_wready,
    output logic [1:0]                          s_axi_bresp,
    output logic                                s_axi_bvalid,
    input  logic                                s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic [2:0]                          s_axi_arprot,
    input  logic                                s_axi_arvalid,
    output logic                                s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                          s_axi_rresp,
    output logic                                s_axi_rvalid,
    input  logic                                s_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]                 wr_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = addr_lsb(DW);
    localparam int IW       = AW - ADDR_LSB;
    localparam int RIW      = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;
    localparam logic [IW:0] C_NREGS = (IW+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DW-1:0] r_regs;
    logic [NUM_REGS-1:0][DW-1:0] w_ro;
    logic                        r_rdy_en;
    logic                        r_bvalid, r_rvalid;
    logic [1:0]                  r_bresp, r_rresp;
    logic [DW-1:0]               r_rdata;
    logic [NUM_REGS-1:0]         r_wr_pulse;

    logic                        w_aw_full, w_w_full, w_commit, w_hold_en;
    logic [AW-1:0]               w_aw_addr;
    logic [DW+SW-1:0]            w_w_bus;
    logic [DW-1:0]               w_wdata;
    logic [SW-1:0]               w_wstrb;

    assign w_ro    = ro_in;
    assign reg_out = r_regs;

    // Readies stay low through reset and while a write response is outstanding.
    assign w_hold_en = r_rdy_en & ~r_bvalid;
    assign w_commit  = w_aw_full & w_w_full & ~r_bvalid;

    fake_rd_axi_hold #(.W(AW)) u_aw_hold (
        .i_clk   (s_axi_aclk),
        .i_rst   (s_axi_areset),
        .i_en    (w_hold_en),
        .i_valid (s_axi_awvalid),
        .o_ready (s_axi_awready),
        .i_data  (s_axi_awaddr),
        .i_clr   (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    fake_rd_axi_hold #(.W(DW+SW)) u_w_hold (
        .i_clk   (s_axi_aclk),
        .i_rst   (s_axi_areset),
        .i_en    (w_hold_en),
        .i_valid (s_axi_wvalid),
        .o_ready (s_axi_wready),
        .i_data  ({s_axi_wstrb, s_axi_wdata}),
        .i_clr   (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_bus)
    );

    assign {w_wstrb, w_wdata} = w_w_bus;

    // All upper address bits take part in the range check so aliases never hit a register.
    logic [IW-1:0]  w_wr_idx, w_rd_idx;
    logic [RIW-1:0] w_wr_ridx, w_rd_ridx;
    logic           w_wr_inr, w_wr_ro, w_rd_inr;

    assign w_wr_idx  = w_aw_addr[AW-1:ADDR_LSB];
    assign w_rd_idx  = s_axi_araddr[AW-1:ADDR_LSB];
    assign w_wr_ridx = w_wr_idx[RIW-1:0];
    assign w_rd_ridx = w_rd_idx[RIW-1:0];
    assign w_wr_inr  = {1'b0, w_wr_idx} < C_NREGS;
    assign w_rd_inr  = {1'b0, w_rd_idx} < C_NREGS;
    assign w_wr_ro   = w_wr_inr & RO_MASK[w_wr_ridx];

    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        w_aw_addr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    logic [1:0]    w_bresp, w_rresp;
    logic [DW-1:0] w_rdata;

    always_comb begin
        w_bresp = RESP_OKAY;
        w_rresp = RESP_OKAY;
`ifdef FAKE_RD_SLVERR_EN
        if (!w_wr_inr)    w_bresp = RESP_DECERR;
        else if (w_wr_ro) w_bresp = RESP_SLVERR;
        if (!w_rd_inr)    w_rresp = RESP_DECERR;
`endif
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd_inr) w_rdata = RO_MASK[w_rd_ridx] ? w_ro[w_rd_ridx] : r_regs[w_rd_ridx];
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_regs <= '0;
        end else if (w_commit && w_wr_inr && !w_wr_ro) begin
            for (int b = 0; b < SW; b++)
                if (w_wstrb[b]) r_regs[w_wr_ridx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rdy_en   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_bresp;
                if (w_wr_inr && !w_wr_ro) r_wr_pulse[w_wr_ridx] <= 1'b1;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign s_axi_arready = r_rdy_en & ~r_rvalid;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_rresp;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign wr_pulse     = r_wr_pulse;

endmodule

// File: tb/tb_fake_rd_axi_regbank.sv
// Self-checking bench for fake_rd_axi_regbank: vector table, corner sequences, random vs model.
module tb_fake_rd_axi_regbank;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam logic [NR-1:0] ROM = 16'h0020;

    logic             clk, rst;
    logic [AW-1:0]    awaddr, araddr;
    logic [2:0]       awprot, arprot;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [DW-1:0]    wdata, rdata;
    logic [DW/8-1:0]  wstrb;
    logic [1:0]       bresp, rresp;
    logic [NR*DW-1:0] reg_out, ro_in;
    logic [NR-1:0]    wr_pulse;

    fake_rd_axi_regbank #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(ROM)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: register words, plus expected and observed pulse counts.
    logic [DW-1:0] m_regs [NR];
    int            exp_pulse [NR];
    int            pulse_cnt [NR];

    initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
    always @(negedge clk)
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;

    function automatic bit m_is_rw(input int idx);
        return idx < NR && !ROM[idx];
    endfunction

    function automatic logic [DW-1:0] m_read(input int idx);
        if (idx >= NR) return '0;
        if (ROM[idx])  return ro_in[idx*DW +: DW];
        return m_regs[idx];
    endfunction

    function automatic logic [1:0] m_wresp(input int idx);
`ifdef FAKE_RD_SLVERR_EN
        if (idx >= NR) return 2'b11;
        if (ROM[idx])  return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_rresp(input int idx);
`ifdef FAKE_RD_SLVERR_EN
        if (idx >= NR) return 2'b11;
`endif
        return 2'b00;
    endfunction

    task automatic m_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
        if (m_is_rw(idx)) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
            exp_pulse[idx]++;
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input int idx, input logic [1:0] lo);
        logic [5:0] i6;
        i6 = idx[5:0];
        return {i6, lo};
    endfunction

    task automatic send_aw(input logic [AW-1:0] a);
        int n;
        n = 0;
        awaddr = a; awvalid = 1'b1;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("aw_timeout", 1, 0);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s);
        int n;
        n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("w_timeout", 1, 0);
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("ar_timeout", 1, 0);
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n;
        n = 0;
        bready = 1'b1;
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("b_timeout", 1, 0);
        resp = bresp;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic wait_r(output logic [DW-1:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        rready = 1'b1;
        while (!rvalid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("r_timeout", 1, 0);
        d = rdata; resp = rresp;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic axi_write(input int idx, input logic [1:0] lo, input logic [DW-1:0] d,
                             input logic [3:0] s, input int awd, input int wd, output logic [1:0] resp);
        fork
            begin repeat (awd) @(negedge clk); send_aw(mk_addr(idx, lo)); end
            begin repeat (wd) @(negedge clk); send_w(d, s); end
        join
        wait_b(resp);
    endtask

    task automatic axi_read(input int idx, input logic [1:0] lo, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        send_ar(mk_addr(idx, lo));
        wait_r(d, resp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid, bresp, rresp}, 6'b0);
        chk("rst_rdata", rdata, 0);
        chk("rst_reg_out", (reg_out == '0), 1);
        chk("rst_wr_pulse", wr_pulse, 0);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_readies", {awready, wready, arready}, 3'b111);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]    r;
        logic [DW-1:0] d;
        logic          ok;
        logic [1:0]    r0;
        logic [DW-1:0] d0;

        tbl[0] = '{0, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
        tbl[1] = '{1, 32'hABCD0001, 4'hF, 32'hABCD0001};
        tbl[2] = '{2, 32'hDEAD0011, 4'hF, 32'hDEAD0011};
        tbl[3] = '{3, 32'hBEEF0011, 4'hF, 32'hBEEF0011};
        tbl[4] = '{1, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
        tbl[5] = '{1, 32'h12345678, 4'b0101, 32'hFF34FF78};
        tbl[6] = '{8, 32'hFFFFFFFF, 4'h0, 32'h00000000};

        rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < NR; i++) begin
            ro_in[i*DW +: DW] = $urandom;
            exp_pulse[i] = 0;
            m_regs[i] = '0;
        end
        ro_in[5*DW +: DW] = 32'hCAFE0005;
        do_reset();

        // Table: write, read back, compare with the fixed expected word.
        for (int i = 0; i < 7; i++) begin
            axi_write(tbl[i].idx, 2'b00, tbl[i].d, tbl[i].s, 0, 0, r);
            m_write(tbl[i].idx, tbl[i].d, tbl[i].s);
            chk($sformatf("tbl%0d_bresp", i), r, 2'b00);
            axi_read(tbl[i].idx, 2'b00, d, r);
            chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
            chk($sformatf("tbl%0d_rresp", i), r, 2'b00);
            if (i == 3)
                for (int k = 0; k < 4; k++) chk($sformatf("pulse_once_%0d", k), pulse_cnt[k], 1);
        end
        chk("strb0_pulse8", pulse_cnt[8], 1);

        // W arrives 5 cycles ahead of AW; commit waits for AW.
        send_w(32'h5A5A5A5A, 4'hF);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bvalid || reg_out[2*DW +: DW] !== 32'hDEAD0011) ok = 1'b0;
        end
        chk("w_early_no_commit", ok, 1);
        send_aw(mk_addr(2, 2'b00));
        @(negedge clk);
        chk("aw_late_bvalid_c1", bvalid, 0);
        @(negedge clk);
        chk("aw_late_bvalid_c2", {bvalid, wr_pulse[2]}, 2'b11);
        wait_b(r);
        m_write(2, 32'h5A5A5A5A, 4'hF);
        chk("aw_late_reg", reg_out[2*DW +: DW], 32'h5A5A5A5A);

        // RO register: write ignored, read returns the status word.
        axi_write(5, 2'b00, 32'h0, 4'hF, 0, 0, r);
        m_write(5, 32'h0, 4'hF);
        chk("ro_bresp", r, m_wresp(5));
        axi_read(5, 2'b00, d, r);
        chk("ro_rdata", d, 32'hCAFE0005);
        chk("ro_no_pulse", pulse_cnt[5], 0);

        // Read and commit to the same register on the same edge returns the old value.
        fork
            send_aw(mk_addr(2, 2'b00));
            send_w(32'h77778888, 4'hF);
            begin @(posedge clk); #1 send_ar(mk_addr(2, 2'b00)); end
        join
        wait_r(d, r);
        wait_b(r0);
        chk("rw_same_edge_old", d, 32'h5A5A5A5A);
        m_write(2, 32'h77778888, 4'hF);

        // Back-pressure on B then R.
        fork
            send_aw(mk_addr(3, 2'b00));
            send_w(32'h0BADF00D, 4'hF);
        join
        m_write(3, 32'h0BADF00D, 4'hF);
        while (!bvalid) @(negedge clk);
        r0 = bresp;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bvalid || bresp !== r0 || awready || wready) ok = 1'b0;
        end
        chk("b_stall_stable", ok, 1);
        wait_b(r);
        send_ar(mk_addr(3, 2'b00));
        while (!rvalid) @(negedge clk);
        d0 = rdata;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rvalid || rdata !== d0 || arready) ok = 1'b0;
        end
        chk("r_stall_stable", ok, 1);
        chk("r_stall_data", d0, 32'h0BADF00D);
        wait_r(d, r);

        // Randomised traffic against the model, including out-of-range and odd strobes.
        for (int it = 0; it < 150; it++) begin
            int            idx;
            logic [1:0]    lo;
            logic [DW-1:0] wd;
            logic [3:0]    s;
            idx = $urandom_range(0, 19);
            lo  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                s  = 4'($urandom_range(0, 15));
                axi_write(idx, lo, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
                chk($sformatf("rnd%0d_bresp_idx%0d", it, idx), r, m_wresp(idx));
                m_write(idx, wd, s);
            end else begin
                axi_read(idx, lo, d, r);
                chk($sformatf("rnd%0d_rdata_idx%0d", it, idx), d, m_read(idx));
                chk($sformatf("rnd%0d_rresp_idx%0d", it, idx), r, m_rresp(idx));
            end
        end
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("reg_out_%0d", i), reg_out[i*DW +: DW], m_regs[i]);
            chk($sformatf("pulse_cnt_%0d", i), pulse_cnt[i], exp_pulse[i]);
        end

        // Out-of-range read, then reset with a write response pending.
        axi_read(NR, 2'b00, d, r);
        chk("oor_rdata", d, 0);
        chk("oor_rresp", r, m_rresp(NR));
        fork
            send_aw(mk_addr(0, 2'b00));
            send_w(32'hFEEDFACE, 4'hF);
        join
        m_write(0, 32'hFEEDFACE, 4'hF);
        while (!bvalid) @(negedge clk);
        chk("pre_rst_reg0", reg_out[0 +: DW], 32'hFEEDFACE);
        do_reset();
        chk("post_rst_bvalid", bvalid, 0);
        chk("post_rst_reg_out", (reg_out == '0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
